// File: rtl/crt_line_fetch_if.sv
// Memory read port between the CRT line fetcher (master) and the memory arbiter/controller (slave).
interface crt_line_fetch_if #(
  parameter int AW = 20,
  parameter int DW = 32
);
  logic          mem_rd_req;
  logic [AW-1:0] mem_addr;
  logic          mem_rd_ack;
  logic [DW-1:0] mem_rdata;

  modport master (output mem_rd_req, mem_addr, input mem_rd_ack, mem_rdata);
  modport slave  (input mem_rd_req, mem_addr, output mem_rd_ack, mem_rdata);
endinterface

// File: rtl/crt_line_fetch.sv
// CRT ping-pong line buffer: fills buffers A/B from memory on arbiter grant and
// drains them alternately to the CRT pixel pipeline; restarts on each CRT line end.
module crt_line_fetch #(
  parameter int DW    = 32,
  parameter int DEPTH = 16,
  parameter int AW    = 20
) (
  input  logic          mem_clk,
  input  logic          hreset_n,
  input  logic          crt_line_end_tgl,
  input  logic [AW-1:0] line_start_addr,
  input  logic          crt_gnt,
  input  logic          crt_pop,
  crt_line_fetch_if.master mem,
  output logic          crt_req,
  output logic          a_empty,
  output logic          b_empty,
  output logic          a_full_done,
  output logic          b_full_done,
  output logic          sync_crt_line_end,
  output logic [DW-1:0] crt_data,
  output logic          crt_data_valid,
  output logic          underrun
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, SEL, FILL} fill_state_e;

  fill_state_e   state_q, state_d;
  logic          s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic          line_end_q, line_end_d;
  logic          gnt_prev_q, gnt_prev_d;
  logic          crt_req_q, crt_req_d;
  logic [1:0]    full_q, full_d;
  logic          fill_active_q, fill_active_d;
  logic          target_q, target_d;      // 0 = buffer A, 1 = buffer B
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          rbuf_q, rbuf_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          mem_rd_req_q, mem_rd_req_d;
  logic          a_done_q, a_done_d, b_done_q, b_done_d;
  logic [DW-1:0] crt_data_q, crt_data_d;
  logic          valid_q, valid_d;
  logic          underrun_q, underrun_d;
  logic          wr_en, abort;
  logic [DW-1:0] rd_word;

  logic [DW-1:0] line_mem [2*DEPTH];

  // A buffer being filled is neither empty nor full until its last word lands.
  assign a_empty = ~full_q[0] & ~(fill_active_q & ~target_q);
  assign b_empty = ~full_q[1] & ~(fill_active_q &  target_q);
  assign rd_word = line_mem[{rbuf_q, rptr_q}];

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    s1_d          = crt_line_end_tgl;
    s2_d          = s1_q;
    s3_d          = s2_q;
    line_end_d    = s2_q ^ s3_q;
    gnt_prev_d    = crt_gnt;
    crt_req_d     = (a_empty | b_empty) & ~crt_gnt & ~line_end_q;
    full_d        = full_q;
    fill_active_d = fill_active_q;
    target_d      = target_q;
    wptr_d        = wptr_q;
    rptr_d        = rptr_q;
    rbuf_d        = rbuf_q;
    mem_addr_d    = mem_addr_q;
    mem_rd_req_d  = mem_rd_req_q;
    a_done_d      = 1'b0;
    b_done_d      = 1'b0;
    crt_data_d    = crt_data_q;
    valid_d       = 1'b0;
    underrun_d    = 1'b0;
    wr_en         = 1'b0;
    abort         = 1'b0;

    // Drain side: only a completely filled buffer may be popped.
    if (crt_pop) begin
      if (full_q[rbuf_q]) begin
        crt_data_d = rd_word;
        valid_d    = 1'b1;
        rptr_d     = rptr_q + PW'(1);
        if (rptr_q == LAST) begin
          full_d[rbuf_q] = 1'b0;
          rbuf_d         = ~rbuf_q;
        end
      end else begin
        underrun_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (crt_gnt && !gnt_prev_q) state_d = SEL;
      end
      SEL: begin
        state_d = IDLE;
        if (crt_gnt && (a_empty || b_empty)) begin
          target_d      = ~a_empty;
          fill_active_d = 1'b1;
          wptr_d        = '0;
          mem_rd_req_d  = 1'b1;
          state_d       = FILL;
        end
      end
      FILL: begin
        if (mem.mem_rd_ack && wptr_q == LAST) begin
          // The last word completes the fill even if the grant drops with it.
          wr_en            = 1'b1;
          wptr_d           = '0;
          mem_addr_d       = mem_addr_q + AW'(1);
          full_d[target_q] = 1'b1;
          a_done_d         = ~target_q;
          b_done_d         = target_q;
          fill_active_d    = 1'b0;
          mem_rd_req_d     = 1'b0;
          state_d          = IDLE;
        end else if (!crt_gnt) begin
          abort = 1'b1;
        end else if (mem.mem_rd_ack) begin
          wr_en      = 1'b1;
          wptr_d     = wptr_q + PW'(1);
          mem_addr_d = mem_addr_q + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Partial fills are discarded; mem_addr keeps advancing from where it stopped.
    if (abort) begin
      state_d       = IDLE;
      fill_active_d = 1'b0;
      wptr_d        = '0;
      mem_rd_req_d  = 1'b0;
    end

    if (line_end_q) begin
      state_d       = IDLE;
      full_d        = '0;
      fill_active_d = 1'b0;
      wptr_d        = '0;
      rptr_d        = '0;
      rbuf_d        = 1'b0;
      mem_addr_d    = line_start_addr;
      mem_rd_req_d  = 1'b0;
      a_done_d      = 1'b0;
      b_done_d      = 1'b0;
      crt_data_d    = crt_data_q;
      valid_d       = 1'b0;
      underrun_d    = 1'b0;
      wr_en         = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge mem_clk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q       <= IDLE;
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      s3_q          <= 1'b0;
      line_end_q    <= 1'b0;
      gnt_prev_q    <= 1'b0;
      crt_req_q     <= 1'b0;
      full_q        <= '0;
      fill_active_q <= 1'b0;
      target_q      <= 1'b0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      rbuf_q        <= 1'b0;
      mem_addr_q    <= '0;
      mem_rd_req_q  <= 1'b0;
      a_done_q      <= 1'b0;
      b_done_q      <= 1'b0;
      crt_data_q    <= '0;
      valid_q       <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      s3_q          <= s3_d;
      line_end_q    <= line_end_d;
      gnt_prev_q    <= gnt_prev_d;
      crt_req_q     <= crt_req_d;
      full_q        <= full_d;
      fill_active_q <= fill_active_d;
      target_q      <= target_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      rbuf_q        <= rbuf_d;
      mem_addr_q    <= mem_addr_d;
      mem_rd_req_q  <= mem_rd_req_d;
      a_done_q      <= a_done_d;
      b_done_q      <= b_done_d;
      crt_data_q    <= crt_data_d;
      valid_q       <= valid_d;
      underrun_q    <= underrun_d;
    end
  end

  // NOTE: buffer storage has no reset; the full flags guard every read, so
  // stale contents are never observed.
  always_ff @(posedge mem_clk) begin
    if (wr_en) line_mem[{target_q, wptr_q}] <= mem.mem_rdata;
  end

  assign crt_req           = crt_req_q;
  assign a_full_done       = a_done_q;
  assign b_full_done       = b_done_q;
  assign sync_crt_line_end = line_end_q;
  assign mem.mem_rd_req    = mem_rd_req_q;
  assign mem.mem_addr      = mem_addr_q;
  assign crt_data          = crt_data_q;
  assign crt_data_valid    = valid_q;
  assign underrun          = underrun_q;
endmodule

// File: tb/tb_crt_line_fetch.sv
// Scoreboard bench for crt_line_fetch: fills are issued with directed data, popped
// words are checked by a monitor against the queue of completed-fill data.
module tb_crt_line_fetch;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 20;

  logic          mem_clk = 1'b0;
  logic          hreset_n = 1'b0;
  logic          crt_line_end_tgl = 1'b0;
  logic [AW-1:0] line_start_addr = '0;
  logic          crt_gnt = 1'b0;
  logic          crt_pop = 1'b0;
  logic          crt_req, a_empty, b_empty, a_full_done, b_full_done;
  logic          sync_crt_line_end, crt_data_valid, underrun;
  logic [DW-1:0] crt_data;

  crt_line_fetch_if #(.AW(AW), .DW(DW)) mem_if ();

  crt_line_fetch #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .mem_clk          (mem_clk),
    .hreset_n         (hreset_n),
    .crt_line_end_tgl (crt_line_end_tgl),
    .line_start_addr  (line_start_addr),
    .crt_gnt          (crt_gnt),
    .crt_pop          (crt_pop),
    .mem              (mem_if),
    .crt_req          (crt_req),
    .a_empty          (a_empty),
    .b_empty          (b_empty),
    .a_full_done      (a_full_done),
    .b_full_done      (b_full_done),
    .sync_crt_line_end(sync_crt_line_end),
    .crt_data         (crt_data),
    .crt_data_valid   (crt_data_valid),
    .underrun         (underrun)
  );

  always #5 mem_clk = ~mem_clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  logic [DW-1:0] sb_q [$];
  logic [DW-1:0] exp_w;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every crt_data_valid pulse must match the oldest expected word.
  always @(negedge mem_clk) begin
    if (hreset_n && crt_data_valid) begin
      if (sb_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL sb_unexpected_valid: got 0x%0h expected no output", crt_data);
      end else begin
        exp_w = sb_q.pop_front();
        check("sb_crt_data", crt_data, exp_w);
      end
    end
  end

  // mode 0: complete fill; mode 1: drop grant after n acks; mode 2: stop acking, keep grant
  task automatic do_fill(input int n, input logic [DW-1:0] d0, input logic [AW-1:0] a0,
                         input bit to_b, input int mode, input string tag);
    logic [DW-1:0] tmp [$];
    logic [AW-1:0] ea;
    bit spur;
    crt_gnt = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge mem_clk);
      if (mem_if.mem_rd_req) break;
    end
    check({tag, "_req_seen"}, mem_if.mem_rd_req, 1);
    spur = 1'b0;
    for (int i = 0; i < n; i++) begin
      ea = a0 + AW'(i);
      mem_if.mem_rdata  = d0 + DW'(i);
      mem_if.mem_rd_ack = 1'b1;
      tmp.push_back(d0 + DW'(i));
      check($sformatf("%s_addr%0d", tag, i), mem_if.mem_addr, ea);
      @(negedge mem_clk);
      if (i < n - 1 && (a_full_done || b_full_done)) spur = 1'b1;
    end
    mem_if.mem_rd_ack = 1'b0;
    check({tag, "_early_done"}, spur, 0);
    if (mode == 0) begin
      check({tag, "_a_full_done"}, a_full_done, !to_b);
      check({tag, "_b_full_done"}, b_full_done, to_b);
      check({tag, "_req_drop"}, mem_if.mem_rd_req, 0);
      crt_gnt = 1'b0;
      foreach (tmp[j]) sb_q.push_back(tmp[j]);
      @(negedge mem_clk);
      check({tag, "_done_once"}, a_full_done | b_full_done, 0);
    end else if (mode == 1) begin
      crt_gnt = 1'b0;
      @(negedge mem_clk);
      check({tag, "_abort_empty"}, to_b ? b_empty : a_empty, 1);
      check({tag, "_abort_req"}, mem_if.mem_rd_req, 0);
      check({tag, "_abort_nodone"}, a_full_done | b_full_done, 0);
    end
  endtask

  task automatic line_end(input logic [AW-1:0] addr, input string tag);
    bit seen, spur;
    int lat;
    seen = 1'b0; spur = 1'b0; lat = 0;
    line_start_addr  = addr;
    crt_line_end_tgl = ~crt_line_end_tgl;
    for (int k = 1; k <= 6; k++) begin
      @(negedge mem_clk);
      if (a_full_done || b_full_done) spur = 1'b1;
      if (sync_crt_line_end) begin
        seen = 1'b1;
        lat  = k;
        break;
      end
    end
    check({tag, "_sync_seen"}, seen, 1);
    check({tag, "_sync_within3"}, (lat >= 2 && lat <= 3), 1);
    sb_q.delete();
    @(negedge mem_clk);
    if (a_full_done || b_full_done) spur = 1'b1;
    check({tag, "_sync_one_cycle"}, sync_crt_line_end, 0);
    check({tag, "_no_full_done"}, spur, 0);
    check({tag, "_a_empty"}, a_empty, 1);
    check({tag, "_b_empty"}, b_empty, 1);
    check({tag, "_mem_addr"}, mem_if.mem_addr, addr);
    check({tag, "_req_off"}, mem_if.mem_rd_req, 0);
  endtask

  task automatic pop_words(input int n);
    crt_pop = 1'b1;
    repeat (n) @(negedge mem_clk);
    crt_pop = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit und;
    mem_if.mem_rd_ack = 1'b0;
    mem_if.mem_rdata  = '0;
    repeat (3) @(negedge mem_clk);

    // Reset state
    check("rst_a_empty", a_empty, 1);
    check("rst_b_empty", b_empty, 1);
    check("rst_crt_req", crt_req, 0);
    check("rst_mem_rd_req", mem_if.mem_rd_req, 0);
    check("rst_mem_addr", mem_if.mem_addr, 0);
    check("rst_crt_data", crt_data, 0);
    check("rst_pulses", {a_full_done, b_full_done, sync_crt_line_end, crt_data_valid, underrun}, 0);
    hreset_n = 1'b1;
    repeat (2) @(negedge mem_clk);
    check("crt_req_after_reset", crt_req, 1);

    // Load the first line address
    line_end(20'h00040, "le0");

    // Fill A from 0x40
    do_fill(16, 32'h100, 20'h00040, 1'b0, 0, "fillA");
    check("t1_a_empty", a_empty, 0);
    check("t1_b_empty", b_empty, 1);
    check("t1_crt_req", crt_req, 1);

    // Fill B, then drain both buffers
    do_fill(16, 32'h110, 20'h00050, 1'b1, 0, "fillB");
    check("t2_crt_req_both_full", crt_req, 0);
    und = 1'b0;
    crt_pop = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge mem_clk);
      if (underrun) und = 1'b1;
      if (i == 14) check("t2_a_full_at15", a_empty, 0);
      if (i == 15) check("t2_a_empty_at16", a_empty, 1);
      if (i == 30) check("t2_b_full_at31", b_empty, 0);
    end
    crt_pop = 1'b0;
    check("t2_b_empty_at32", b_empty, 1);
    check("t2_no_underrun", und, 0);

    // Underrun with both buffers empty
    crt_pop = 1'b1;
    @(negedge mem_clk);
    crt_pop = 1'b0;
    check("t3_underrun", underrun, 1);
    check("t3_no_valid", crt_data_valid, 0);
    check("t3_data_hold", crt_data, 32'h11F);
    @(negedge mem_clk);
    check("t3_underrun_pulse", underrun, 0);

    // Grant drop after 7 acks, then refill A from word 0 continuing at base+7
    do_fill(7, 32'h200, 20'h00060, 1'b0, 1, "abortA");
    do_fill(16, 32'h300, 20'h00067, 1'b0, 0, "refillA");
    check("t5_a_full", a_empty, 0);
    check("t5_b_empty", b_empty, 1);
    pop_words(16);

    // Address wrap across 0xFFFFF
    line_end(20'hFFFF8, "le_wrap");
    do_fill(16, 32'h400, 20'hFFFF8, 1'b0, 0, "wrapA");
    do_fill(16, 32'h410, 20'h00008, 1'b1, 0, "wrapB");
    pop_words(32);

    // Line end during a fill after 5 acks
    do_fill(5, 32'h500, 20'h00018, 1'b0, 2, "midA");
    line_end(20'h12345, "le_mid");
    crt_gnt = 1'b0;
    crt_pop = 1'b1;
    @(negedge mem_clk);
    crt_pop = 1'b0;
    check("t4_underrun_after_abort", underrun, 1);

    repeat (3) @(negedge mem_clk);
    check("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
